// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative radix-2 multiply/divide unit.
// ALU ops complete in one cycle; M-extension ops take XLEN+1 cycles.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      aluop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [SHW-1:0]      cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opnd_r;
    logic [2:0]          f3_r;
    logic                neg_q_r, neg_r_r;

    logic                is_m_s, accept_s, lt_s, ltu_s;
    logic                sa_s, sb_s, an_s, bn_s;
    logic [SHW-1:0]      shamt_s;
    logic signed [XLEN-1:0] sra_s;
    logic [XLEN-1:0]     alu_s, am_s, bm_s, fin_s;
    logic [XLEN:0]       sum_s, trial_s;
    logic [2*XLEN-1:0]   mul_next_s, div_next_s, full_s;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn & v[XLEN-1]) ? neg_w(v) : v;
    endfunction

    assign in_ready = (state_r == S_IDLE);
    assign busy     = ~in_ready;
    assign is_m_s   = (aluop == 2'b10) & opb5 & (funct7 == 7'b0000001);
    assign accept_s = in_valid & in_ready & ~flush;
    assign shamt_s  = b[SHW-1:0];
    assign lt_s     = $signed(a) < $signed(b);
    assign ltu_s    = a < b;
    assign sra_s    = $signed(a) >>> shamt_s;

    // Operand signedness: mul group signs a unless mulhu, b only for mul/mulh; div/rem sign both.
    assign sa_s = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sb_s = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign an_s = sa_s & a[XLEN-1];
    assign bn_s = sb_s & b[XLEN-1];
    assign am_s = mag(a, sa_s);
    assign bm_s = mag(b, sb_s);

    // Single-cycle ALU result
    always_comb begin
        alu_s = '0;
        case (aluop)
            2'b00: alu_s = a + b;
            2'b01: alu_s = a - b;
            2'b11: alu_s = {{(XLEN-1){1'b0}}, lt_s};
            2'b10: begin
                case (funct3)
                    3'b000: alu_s = (funct7[5] & opb5) ? (a - b) : (a + b);
                    3'b001: alu_s = a << shamt_s;
                    3'b010: alu_s = {{(XLEN-1){1'b0}}, lt_s};
                    3'b011: alu_s = {{(XLEN-1){1'b0}}, ltu_s};
                    3'b100: alu_s = a ^ b;
                    3'b101: alu_s = funct7[5] ? sra_s : (a >> shamt_s);
                    3'b110: alu_s = a | b;
                    3'b111: alu_s = a & b;
                    default: alu_s = '0;
                endcase
            end
            default: alu_s = '0;
        endcase
    end

    // One iteration step: acc holds {hi, lo} = {product high, multiplier} or {remainder, quotient}
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        mul_next_s = {sum_s, acc_r[XLEN-1:1]};
        trial_s    = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]} - {1'b0, opnd_r};
        if (trial_s[XLEN] == 1'b0) begin
            div_next_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {acc_r[2*XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and half/quotient/remainder selection
    always_comb begin
        full_s = neg_q_r ? neg_d(acc_r) : acc_r;
        fin_s  = '0;
        if (f3_r[2]) begin
            if (f3_r[1]) begin
                fin_s = neg_r_r ? neg_w(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
            end else begin
                fin_s = neg_q_r ? neg_w(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
            end
        end else if (f3_r[1:0] == 2'b00) begin
            fin_s = full_s[XLEN-1:0];
        end else begin
            fin_s = full_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s & is_m_s) begin
                    state_s = funct3[2] ? S_DIV : S_MUL;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else if (cnt_r == SHW'(XLEN - 1)) begin
                    state_s = S_FIN;
                end else begin
                    state_s = state_r;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            opnd_r    <= '0;
            f3_r      <= 3'b000;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s & is_m_s) begin
                        cnt_r   <= '0;
                        f3_r    <= funct3;
                        acc_r   <= {{XLEN{1'b0}}, (funct3[2] ? am_s : bm_s)};
                        opnd_r  <= funct3[2] ? bm_s : am_s;
                        neg_q_r <= funct3[2] ? ((an_s ^ bn_s) & (b != '0)) : (an_s ^ bn_s);
                        neg_r_r <= an_s;
                    end else if (accept_s) begin
                        result    <= alu_s;
                        out_valid <= 1'b1;
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + SHW'(1);
                        acc_r <= (state_r == S_MUL) ? mul_next_s : div_next_s;
                    end
                end
                S_FIN: begin
                    cnt_r <= '0;
                    if (!flush) begin
                        result    <= fin_s;
                        out_valid <= 1'b1;
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are queued at issue and
// compared when out_valid pulses.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        opb5 = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'h00;
    logic [1:0]  aluop = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int          nres = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] last_res = 32'd0;
    logic [31:0] mon_exp;
    string       mon_tag;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opb5(opb5), .funct3(funct3), .funct7(funct7), .aluop(aluop),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] aop, input logic ob5,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, syu;
        logic [63:0]        ux, uy, p;
        logic signed [31:0] t;
        logic [4:0]         sh;
        sh  = y[4:0];
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        syu = uy;
        if (aop == 2'b00) return x + y;
        if (aop == 2'b01) return x - y;
        if (aop == 2'b11) return {31'd0, $signed(x) < $signed(y)};
        if (ob5 && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = sx * sy; return p[31:0]; end
                3'd1: begin p = sx * sy; return p[63:32]; end
                3'd2: begin p = sx * syu; return p[63:32]; end
                3'd3: begin p = ux * uy; return p[63:32]; end
                3'd4: begin
                    if (y == 32'd0) return 32'hFFFF_FFFF;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                    t = $signed(x) / $signed(y);
                    return t;
                end
                3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
                3'd6: begin
                    if (y == 32'd0) return x;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                    t = $signed(x) % $signed(y);
                    return t;
                end
                default: return (y == 32'd0) ? x : x % y;
            endcase
        end
        case (f3)
            3'd0: return (f7[5] && ob5) ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return {31'd0, $signed(x) < $signed(y)};
            3'd3: return {31'd0, x < y};
            3'd4: return x ^ y;
            3'd5: begin
                if (f7[5]) begin
                    t = $signed(x) >>> sh;
                    return t;
                end
                return x >> sh;
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Scoreboard monitor: sample away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            last_res <= 32'd0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check_eq(mon_tag, result, mon_exp);
                last_res <= mon_exp;
                nres     <= nres + 1;
            end
        end
    end

    task automatic send(input logic [1:0] aop, input logic ob5, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y,
                        input bit expect_out, input logic [31:0] e, input string tag);
        int n;
        aluop = aop; opb5 = ob5; funct3 = f3; funct7 = f7; a = x; b = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
        if (expect_out) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic [1:0] aop, input logic ob5, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        send(aop, ob5, f3, f7, x, y, 1'b1, ref_model(aop, ob5, f3, f7, x, y), tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low, base;
        logic [6:0] f7r;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_result", result, 32'd0);
        reset = 1'b0;

        send(2'b10, 1'b1, 3'b000, 7'h20, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, "sub");
        check_eq("sub_latency", 32'(out_valid), 32'd1);
        send(2'b10, 1'b0, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, "srai");
        send(2'b10, 1'b0, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 1'b1, 32'h0800_0000, "srli");
        send(2'b00, 1'b1, 3'b111, 7'h01, 32'd10, 32'd20, 1'b1, 32'd30, "aluop00_ignores_f");
        send(2'b11, 1'b0, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, "slt_aluop11");
        send(2'b10, 1'b1, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, "sltu");
        drain();

        send(2'b10, 1'b1, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF, "mulh");
        lat = 0; low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("mulh_latency", 32'(lat), 32'd33);
        check_eq("mulh_stall_cycles", 32'(low), 32'(lat));
        check_eq("ready_with_out_valid", 32'(in_ready), 32'd1);

        send(2'b10, 1'b1, 3'b100, 7'h01, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF, "div_by_zero");
        send(2'b10, 1'b1, 3'b110, 7'h01, 32'd7, 32'd0, 1'b1, 32'd7, "rem_by_zero");
        send(2'b10, 1'b1, 3'b101, 7'h01, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF, "divu_by_zero");
        send(2'b10, 1'b1, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, "div_ovf");
        send(2'b10, 1'b1, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, "rem_ovf");
        send(2'b10, 1'b1, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, "rem_neg");
        send(2'b10, 1'b1, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, "div_neg");
        send(2'b10, 1'b1, 3'b000, 7'h01, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, "mul_low");
        send(2'b10, 1'b1, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, "mulhu");
        send(2'b10, 1'b1, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, "mulhsu");
        drain();

        send(2'b10, 1'b1, 3'b101, 7'h01, 32'd100, 32'd7, 1'b0, 32'd0, "divu_flushed");
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_result_kept", result, last_res);
        repeat (40) begin @(posedge clk); #1; end
        send(2'b10, 1'b1, 3'b101, 7'h01, 32'd100, 32'd7, 1'b1, 32'd14, "divu_after_flush");
        drain();

        aluop = 2'b10; opb5 = 1'b1; funct3 = 3'b100; funct7 = 7'h01; a = 32'd9; b = 32'd3;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_wins_m_ready", 32'(in_ready), 32'd1);
        aluop = 2'b00; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_drops_alu", 32'(out_valid), 32'd0);

        send(2'b10, 1'b1, 3'b000, 7'h01, 32'd12345, 32'd678, 1'b0, 32'd0, "mul_reset");
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        base = nres;
        send(2'b10, 1'b1, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'hFF00_FF00, "b2b_xor");
        send(2'b10, 1'b1, 3'b110, 7'h00, 32'h1200_0034, 32'h0056_7800, 1'b1, 32'h1256_7834, "b2b_or");
        send(2'b10, 1'b1, 3'b111, 7'h00, 32'hFFFF_0000, 32'h00FF_FF00, 1'b1, 32'h00FF_0000, "b2b_and");
        send(2'b10, 1'b1, 3'b001, 7'h00, 32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000, "b2b_sll");
        @(negedge clk); #1;
        check_eq("b2b_throughput", 32'(nres - base), 32'd4);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                default: f7r = 7'h01;
            endcase
            sendm(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), f7r,
                  $urandom(), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(), "rand");
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
